// File: rtl/grid_slot_scheduler.sv
// Round-robin arbiter that feeds one shared PR slot and returns results in order using a tag FIFO.
// Defining GRID_SLOT_PERF_EN adds grant/stall performance counters.
module grid_slot_scheduler #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned XLEN            = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*XLEN-1:0] req_rs1,
  input  logic [NUM_REQ*XLEN-1:0] req_rs2,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [XLEN-1:0]         slot_data_in1,
  output logic [XLEN-1:0]         slot_data_in2,
  output logic                    slot_valid_in1,
  output logic                    slot_valid_in2,
  input  logic [XLEN-1:0]         slot_data_out,
  input  logic                    slot_data_valid_out,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [XLEN-1:0]         rsp_data,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    err,
  output logic [31:0]             perf_grants,
  output logic [31:0]             perf_stalls
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MaxCnt  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LastPtr = PW'(MAX_OUTSTANDING - 1);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gnt_idx, cand;
  logic                found, can_grant, push, pop;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wr_q, rd_q;
  logic [IW-1:0]       tag_mem [MAX_OUTSTANDING];
  logic [XLEN-1:0]     rs1_sel, rs2_sel;
  logic [XLEN-1:0]     in1_q, in2_q, rsp_d_q;
  logic                slot_v_q, err_q;
  logic [NUM_REQ-1:0]  rsp_v_q, rsp_v_d;

  // Search starts one past the last granted index; credits come from the registered count only.
  always_comb begin
    found   = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((rr_q + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    can_grant = (state_q == StRun) && (cnt_q < MaxCnt) && rst;
    req_ready = '0;
    if (found && can_grant) req_ready[gnt_idx] = 1'b1;
  end

  assign push = |(req_valid & req_ready);
  assign pop  = slot_data_valid_out && (cnt_q != '0);
  assign rr_d = push ? gnt_idx : rr_q;

  always_comb begin
    rs1_sel = '0;
    rs2_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        rs1_sel = req_rs1[i*XLEN +: XLEN];
        rs2_sel = req_rs2[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rsp_v_d = '0;
    if (pop) rsp_v_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_mem[rd_q];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (flush_req) state_d = StDrain;
      StDrain: if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StRun;
      rr_q     <= LastIdx;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      slot_v_q <= 1'b0;
      rsp_v_q  <= '0;
      rsp_d_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      slot_v_q <= push;
      rsp_v_q  <= rsp_v_d;
      if (push) begin
        wr_q  <= (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
        in1_q <= rs1_sel;
        in2_q <= rs2_sel;
      end
      if (pop) rd_q <= (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
      if (slot_data_valid_out) rsp_d_q <= slot_data_out;
      // A result with no tag in flight is unattributable; flag it and leave the FIFO alone.
      if (slot_data_valid_out && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_q] <= gnt_idx;
  end

  assign slot_data_in1  = in1_q;
  assign slot_data_in2  = in2_q;
  assign slot_valid_in1 = slot_v_q;
  assign slot_valid_in2 = slot_v_q;
  assign rsp_valid      = rsp_v_q;
  assign rsp_data       = rsp_d_q;
  assign flush_done     = (state_q == StDone);
  assign err            = err_q;

`ifdef GRID_SLOT_PERF_EN
  logic [31:0] grants_q, stalls_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (push) grants_q <= grants_q + 32'd1;
      if ((|req_valid) && !push) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_grants = grants_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_grants = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_grid_slot_scheduler.sv
// Directed self-checking bench for grid_slot_scheduler (NUM_REQ=4, MAX_OUTSTANDING=4, XLEN=32).
module tb_grid_slot_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_rs1, req_rs2;
  logic [3:0]   req_ready;
  logic [31:0]  slot_data_in1, slot_data_in2;
  logic         slot_valid_in1, slot_valid_in2;
  logic [31:0]  slot_data_out;
  logic         slot_data_valid_out;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         flush_req, flush_done, err;
  logic [31:0]  perf_grants, perf_stalls;

  logic         slot_auto, man_dv;
  logic [31:0]  man_d;
  logic         s1_v, s2_v;
  logic [31:0]  s1_d, s2_d;

  int n_chk  = 0;
  int n_pass = 0;

  grid_slot_scheduler #(.NUM_REQ(4), .MAX_OUTSTANDING(4), .XLEN(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_rs1             (req_rs1),
    .req_rs2             (req_rs2),
    .req_ready           (req_ready),
    .slot_data_in1       (slot_data_in1),
    .slot_data_in2       (slot_data_in2),
    .slot_valid_in1      (slot_valid_in1),
    .slot_valid_in2      (slot_valid_in2),
    .slot_data_out       (slot_data_out),
    .slot_data_valid_out (slot_data_valid_out),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .flush_req           (flush_req),
    .flush_done          (flush_done),
    .err                 (err),
    .perf_grants         (perf_grants),
    .perf_stalls         (perf_stalls)
  );

  always #5 clk = ~clk;

  // Slot model: sum of operands, returned two cycles after the operand strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_d <= '0;
      s2_d <= '0;
    end else begin
      s1_v <= slot_valid_in1;
      s1_d <= slot_data_in1 + slot_data_in2;
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end

  assign slot_data_valid_out = slot_auto ? s2_v : man_dv;
  assign slot_data_out       = slot_auto ? s2_d : man_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [3:0] v, input logic dv, input logic [31:0] d);
    req_valid = v;
    man_dv    = dv;
    man_d     = d;
    step();
    req_valid = '0;
    man_dv    = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    man_dv    = 1'b0;
    man_d     = '0;
    flush_req = 1'b0;
    slot_auto = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  logic [3:0]  exp_oh [5];
  logic [31:0] exp_d  [5];
  int n_g, n_r;
  logic [31:0] exp_pg, exp_ps;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_oh = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    exp_d  = '{32'h101, 32'h202, 32'h303, 32'h404, 32'h101};
    for (int i = 0; i < 4; i++) begin
      req_rs1[i*32 +: 32] = 32'h100 * (i + 1);
      req_rs2[i*32 +: 32] = i + 1;
    end
    rst = 1'b1; req_valid = '0; man_dv = 1'b0; man_d = '0; flush_req = 1'b0; slot_auto = 1'b0;
    #2 rst = 1'b0;
    req_valid = 4'hF;
    #1;
    check("rst_ready", {28'd0, req_ready}, 32'h0);
    check("rst_slot_valid", {31'd0, slot_valid_in1}, 32'h0);
    check("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    check("rst_err", {31'd0, err}, 32'h0);
    check("rst_flush_done", {31'd0, flush_done}, 32'h0);
    check("rst_perf_grants", perf_grants, 32'h0);
    step();
    rst = 1'b1;
    #1;
    check("first_grant_idx0", {28'd0, req_ready}, 32'h1);
    req_valid = '0;

    // Round-robin with all requesters valid and the automatic slot model.
    do_reset();
    slot_auto = 1'b1;
    n_g = 0;
    n_r = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = (n_g < 5) ? 4'hF : 4'h0;
      #1;
      if (req_ready != '0 && n_g < 5) begin
        check("rr_grant", {28'd0, req_ready}, {28'd0, exp_oh[n_g]});
        n_g++;
      end
      if (rsp_valid != '0 && n_r < 5) begin
        check("rr_rsp_valid", {28'd0, rsp_valid}, {28'd0, exp_oh[n_r]});
        check("rr_rsp_data", rsp_data, exp_d[n_r]);
        n_r++;
      end
      step();
    end
    check("rr_grant_count", n_g, 5);
    check("rr_rsp_count", n_r, 5);

    // Credit exhaustion and return, no same-cycle bypass.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'hF;
      #1;
      check("fill_grant", {28'd0, req_ready}, 32'd1 << k);
      cycle(4'hF, 1'b0, 32'h0);
    end
    req_valid = 4'hF;
    #1;
    check("full_ready", {28'd0, req_ready}, 32'h0);
    man_dv = 1'b1;
    man_d  = 32'h77;
    #1;
    check("no_bypass", {28'd0, req_ready}, 32'h0);
    step();
    man_dv = 1'b0;
    #1;
    check("credit_ready", {28'd0, req_ready}, 32'h1);
    check("credit_rsp_valid", {28'd0, rsp_valid}, 32'h1);
    check("credit_rsp_data", rsp_data, 32'h77);
    req_valid = '0;

    // Single transaction from requester 2.
    do_reset();
    req_rs1[2*32 +: 32] = 32'h10;
    req_rs2[2*32 +: 32] = 32'h20;
    req_valid = 4'b0100;
    #1;
    check("r2_grant", {28'd0, req_ready}, 32'h4);
    check("r2_slot_idle", {31'd0, slot_valid_in1}, 32'h0);
    step();
    req_valid = '0;
    #1;
    check("r2_valid_in1", {31'd0, slot_valid_in1}, 32'h1);
    check("r2_valid_in2", {31'd0, slot_valid_in2}, 32'h1);
    check("r2_data_in1", slot_data_in1, 32'h10);
    check("r2_data_in2", slot_data_in2, 32'h20);
    step();
    check("r2_valid_pulse", {30'd0, slot_valid_in1, slot_valid_in2}, 32'h0);
    man_dv = 1'b1;
    man_d  = 32'h30;
    #1;
    check("r2_rsp_not_yet", {28'd0, rsp_valid}, 32'h0);
    step();
    man_dv = 1'b0;
    check("r2_rsp_valid", {28'd0, rsp_valid}, 32'h4);
    check("r2_rsp_data", rsp_data, 32'h30);
    step();
    check("r2_rsp_pulse", {28'd0, rsp_valid}, 32'h0);
    req_rs1[2*32 +: 32] = 32'h300;
    req_rs2[2*32 +: 32] = 32'h3;

    // Flush with three outstanding.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'hF, 1'b0, 32'h0);
    flush_req = 1'b1;
    cycle(4'h0, 1'b0, 32'h0);
    flush_req = 1'b0;
    req_valid = 4'hF;
    #1;
    check("drain_ready", {28'd0, req_ready}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(4'hF, 1'b1, 32'h50 + k);
      check("drain_rsp_valid", {28'd0, rsp_valid}, 32'd1 << k);
      check("drain_rsp_data", rsp_data, 32'h50 + k);
      check("drain_no_done", {31'd0, flush_done}, 32'h0);
    end
    req_valid = 4'hF;
    #1;
    check("drain_last_ready", {28'd0, req_ready}, 32'h0);
    cycle(4'hF, 1'b0, 32'h0);
    check("flush_done_pulse", {31'd0, flush_done}, 32'h1);
    req_valid = 4'hF;
    #1;
    check("done_ready", {28'd0, req_ready}, 32'h0);
    cycle(4'hF, 1'b0, 32'h0);
    check("flush_done_end", {31'd0, flush_done}, 32'h0);
    req_valid = 4'hF;
    #1;
    check("resume_grant", {28'd0, req_ready}, 32'h8);
    req_valid = '0;

    // Spurious result, sticky err, then asynchronous reset mid-traffic.
    do_reset();
    cycle(4'h0, 1'b1, 32'hDEAD);
    check("err_set", {31'd0, err}, 32'h1);
    check("err_no_rsp", {28'd0, rsp_valid}, 32'h0);
    cycle(4'hF, 1'b0, 32'h0);
    cycle(4'hF, 1'b1, 32'hBEEF);
    req_valid = 4'hF;
    #1;
    check("err_sticky", {31'd0, err}, 32'h1);
    check("mid_rsp_valid", {28'd0, rsp_valid}, 32'h1);
    check("mid_slot_valid", {31'd0, slot_valid_in1}, 32'h1);
    rst = 1'b0;
    #1;
    check("arst_ready", {28'd0, req_ready}, 32'h0);
    check("arst_slot_valid", {30'd0, slot_valid_in1, slot_valid_in2}, 32'h0);
    check("arst_slot_data1", slot_data_in1, 32'h0);
    check("arst_slot_data2", slot_data_in2, 32'h0);
    check("arst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    check("arst_rsp_data", rsp_data, 32'h0);
    check("arst_err", {31'd0, err}, 32'h0);
    check("arst_perf_stalls", perf_stalls, 32'h0);
    req_valid = '0;
    step();
    rst = 1'b1;
    cycle(4'h0, 1'b1, 32'h1234);
    check("post_reset_err", {31'd0, err}, 32'h1);
    check("post_reset_no_rsp", {28'd0, rsp_valid}, 32'h0);

    // 10 transfers and 5 stalled cycles.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(4'hF, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) cycle(4'h0, 1'b1, 32'h0);
    for (int k = 0; k < 4; k++) cycle(4'hF, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) cycle(4'h0, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) cycle(4'hF, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) cycle(4'hF, 1'b0, 32'h0);
`ifdef GRID_SLOT_PERF_EN
    exp_pg = 32'd10;
    exp_ps = 32'd5;
`else
    exp_pg = 32'd0;
    exp_ps = 32'd0;
`endif
    check("perf_grants", perf_grants, exp_pg);
    check("perf_stalls", perf_stalls, exp_ps);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/grid_slot_scheduler.md
GRID_SLOT_SCHEDULER -- requirements
Module: grid_slot_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one PR slot (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum operand pairs in flight in the slot (power of 2).
REQ-003 SHALL have parameter XLEN, default 32, operand/result width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand pair valid.
REQ-007 SHALL have port req_rs1  input  NUM_REQ*XLEN  per-requester operand 1, requester i at bits [i*XLEN +: XLEN].
REQ-008 SHALL have port req_rs2  input  NUM_REQ*XLEN  per-requester operand 2, same packing.
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] and req_ready[i].
REQ-010 SHALL have ports slot_data_in1/slot_data_in2  output  XLEN  operands to slot.
REQ-011 SHALL have ports slot_valid_in1/slot_valid_in2  output  1  operand strobes to slot.
REQ-012 SHALL have ports slot_data_out  input  XLEN and slot_data_valid_out  input  1  slot result.
REQ-013 SHALL have ports rsp_valid  output  NUM_REQ (one-hot) and rsp_data  output  XLEN  result return.
REQ-014 SHALL have ports flush_req  input  1, flush_done  output  1, err  output  1 (sticky).
REQ-015 SHALL have ports perf_grants  output  32 and perf_stalls  output  32.

Function
REQ-016 SHALL grant at most one requester per cycle, round-robin, search starting at (last granted index + 1) mod NUM_REQ.
REQ-017 SHALL drive req_ready combinationally, only in state RUN and only when outstanding < MAX_OUTSTANDING.
REQ-018 SHALL register granted rs1/rs2 and pulse slot_valid_in1 and slot_valid_in2 together for exactly one cycle, one cycle after the transfer.
REQ-019 SHALL push the granted index into an in-order tag FIFO (depth MAX_OUTSTANDING) on each transfer.
REQ-020 SHALL, on slot_data_valid_out, pop the tag FIFO and, one cycle later, assert rsp_valid[tag] for one cycle with rsp_data = registered slot_data_out.
REQ-021 SHALL keep outstanding count (width clog2(MAX_OUTSTANDING)+1): +1 on transfer, -1 on result, unchanged when both occur in one cycle.
REQ-022 SHALL accept a transfer in the same cycle a result frees the last credit only if outstanding < MAX_OUTSTANDING before that cycle (no combinational credit bypass).
REQ-023 SHALL set err and leave count/FIFO unchanged when slot_data_valid_out arrives with an empty tag FIFO.
REQ-024 SHALL implement FSM RUN -> DRAIN on flush_req; DRAIN -> DONE when outstanding == 0; DONE pulses flush_done one cycle, then -> RUN.
REQ-025 SHALL, in DRAIN, deassert all req_ready while still returning results; flush_req in DRAIN/DONE ignored.
REQ-026 SHALL wrap tag FIFO pointers modulo MAX_OUTSTANDING without losing order.

Reset
REQ-027 SHALL, on rst low, immediately clear: req_ready, slot_valid_in*, rsp_valid, flush_done, err, outstanding, FIFO pointers, perf counters; FSM = RUN; RR pointer = NUM_REQ-1 (index 0 first).
REQ-028 SHALL discard in-flight tags on reset mid-operation; slot results arriving after reset set err.
REQ-029 SHALL clear slot_data_in1/2 and rsp_data to 0 on reset.

Configuration
REQ-030 SHALL, with GRID_SLOT_PERF_EN defined, count transfers in perf_grants and cycles with any req_valid but no transfer in perf_stalls (32-bit, wrap).
REQ-031 SHALL, without GRID_SLOT_PERF_EN, tie perf_grants and perf_stalls to 0 and instantiate no counters.

Verification
REQ-032 SHALL cover: req_valid=4'b1111 held, slot returns result 2 cycles later -> grants 0,1,2,3,0 in order, rsp_valid one-hot matches grant order.
REQ-033 SHALL cover: 4 transfers with no results -> outstanding=4, req_ready=0; one result -> req_ready reasserts next cycle.
REQ-034 SHALL cover: requester 2 sends rs1=0x10, rs2=0x20; slot returns 0x30 -> rsp_valid=4'b0100, rsp_data=0x30 one cycle after slot_data_valid_out.
REQ-035 SHALL cover: flush_req with 3 outstanding -> no grants, 3 responses returned, flush_done pulses one cycle after outstanding reaches 0.
REQ-036 SHALL cover: slot_data_valid_out with empty FIFO -> err=1 sticky until reset; reset low mid-traffic -> all outputs 0 immediately.
REQ-037 SHALL cover: with GRID_SLOT_PERF_EN, 10 transfers and 5 stalled cycles -> perf_grants=10, perf_stalls=5; without it -> both 0.
